// File: rtl/fs_dither_core.sv
// rtl/fs_dither_core.sv - Floyd-Steinberg error-diffusion core
// Registered input stage, one-cycle quantize/diffuse, two-slot next-row window plus end-of-row flush.
module fs_dither_core #(
  parameter int FRAME_WIDTH = 320,
  parameter int THRESHOLD   = 128
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        pix_valid_in,
  input  logic [10:0] pix_hcount_in,
  input  logic [9:0]  pix_vcount_in,
  input  logic [7:0]  cur_pixel_in,
  input  logic [7:0]  next_pixel_in,
  input  logic        diffuse_en_in,
  output logic        dith_valid_out,
  output logic        dith_pixel_out,
  output logic [10:0] dith_hcount_out,
  output logic [9:0]  dith_vcount_out,
  output logic        wr_valid_out,
  output logic [8:0]  wr_addr_out,
  output logic [7:0]  wr_data_out,
  output logic        row_overrun_out
);
  localparam logic [10:0] LAST_X = 11'(FRAME_WIDTH - 1);
  localparam logic [7:0]  THRESH = 8'(THRESHOLD);

  typedef enum logic [1:0] {ST_IDLE, ST_ROW, ST_FLUSH} state_t;
  state_t r_state, w_state_nxt;

  logic        r_in_valid;
  logic [10:0] r_in_h;
  logic [9:0]  r_in_v;
  logic [7:0]  r_in_cur;
  logic [7:0]  r_in_next;
  logic        r_in_diff;

  // r_s0 is the slot for column x-1 (still owed d3), r_s1 the slot for column x.
  logic signed [11:0] r_err, r_s0, r_s1;
  logic [10:0]        r_prev_h;

  logic w_is_first, w_is_last, w_in_seq;
  logic w_process, w_restart, w_flush_wr, w_overrun;
  logic signed [11:0] w_err_used, w_s_prev, w_s_cur, w_v, w_e;
  logic signed [11:0] w_d7, w_d5, w_d3, w_d1, w_slot_next;
  logic [7:0]         w_v_clamp;
  logic               w_bit;

  function automatic logic [7:0] clamp8(input logic signed [11:0] a);
    if (a[11])
      return 8'd0;
    else if (|a[10:8])
      return 8'd255;
    else
      return a[7:0];
  endfunction

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_in_valid <= 1'b0;
      r_in_h     <= '0;
      r_in_v     <= '0;
      r_in_cur   <= '0;
      r_in_next  <= '0;
      r_in_diff  <= 1'b0;
    end else begin
      r_in_valid <= pix_valid_in;
      if (pix_valid_in) begin
        r_in_h    <= pix_hcount_in;
        r_in_v    <= pix_vcount_in;
        r_in_cur  <= cur_pixel_in;
        r_in_next <= next_pixel_in;
        r_in_diff <= diffuse_en_in;
      end
    end
  end

  assign w_is_first = (r_in_h == 11'd0);
  assign w_is_last  = (r_in_h == LAST_X);
  assign w_in_seq   = (r_in_h == r_prev_h + 11'd1);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_process   = 1'b0;
    w_restart   = 1'b0;
    w_flush_wr  = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_in_valid && w_is_first) begin
          w_process   = 1'b1;
          w_restart   = 1'b1;
          w_state_nxt = w_is_last ? ST_FLUSH : ST_ROW;
        end
      end
      ST_ROW: begin
        if (r_in_valid) begin
          w_process   = 1'b1;
          w_restart   = w_is_first || !w_in_seq;
          w_state_nxt = w_is_last ? ST_FLUSH : ST_ROW;
        end
      end
      ST_FLUSH: begin
        if (r_in_valid) begin
          // A pixel landing here has no idle gap: it wins, the flush write is lost.
          w_process   = 1'b1;
          w_restart   = 1'b1;
          w_overrun   = 1'b1;
          w_state_nxt = w_is_last ? ST_FLUSH : ST_ROW;
        end else begin
          w_flush_wr  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_err_used  = w_restart ? 12'sd0 : r_err;
    w_s_prev    = w_restart ? 12'sd0 : r_s0;
    w_s_cur     = w_restart ? 12'sd0 : r_s1;
    w_v         = $signed({4'b0000, r_in_cur}) + w_err_used;
    w_v_clamp   = clamp8(w_v);
    w_bit       = r_in_diff ? (w_v_clamp >= THRESH) : (r_in_cur >= THRESH);
    w_e         = r_in_diff ? ($signed({4'b0000, w_v_clamp}) - (w_bit ? 12'sd255 : 12'sd0)) : 12'sd0;
    w_d7        = ((w_e <<< 3) - w_e) >>> 4;
    w_d5        = ((w_e <<< 2) + w_e) >>> 4;
    w_d3        = ((w_e <<< 1) + w_e) >>> 4;
    w_d1        = w_e >>> 4;
    w_slot_next = $signed({4'b0000, r_in_next}) + w_d1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dith_valid_out  <= 1'b0;
      dith_pixel_out  <= 1'b0;
      dith_hcount_out <= '0;
      dith_vcount_out <= '0;
      wr_valid_out    <= 1'b0;
      wr_addr_out     <= '0;
      wr_data_out     <= '0;
      row_overrun_out <= 1'b0;
      r_err           <= '0;
      r_s0            <= '0;
      r_s1            <= '0;
      r_prev_h        <= '0;
    end else begin
      dith_valid_out  <= w_process;
      wr_valid_out    <= (w_process && !w_is_first) || w_flush_wr;
      row_overrun_out <= w_overrun;
      if (w_process) begin
        dith_pixel_out  <= w_bit;
        dith_hcount_out <= r_in_h;
        dith_vcount_out <= r_in_v;
        r_err           <= r_in_diff ? w_d7 : 12'sd0;
        r_s0            <= w_s_cur + w_d5;
        r_s1            <= w_is_last ? 12'sd0 : w_slot_next;
        r_prev_h        <= r_in_h;
        if (!w_is_first) begin
          wr_addr_out <= r_in_h[8:0] - 9'd1;
          wr_data_out <= clamp8(w_s_prev + w_d3);
        end
      end else if (w_flush_wr) begin
        wr_addr_out <= LAST_X[8:0];
        wr_data_out <= clamp8(r_s0);
      end
    end
  end
endmodule

// File: tb/tb_fs_dither_core.sv
// tb/tb_fs_dither_core.sv - randomized scoreboard bench for fs_dither_core
// Array-based row model feeds stamped expectation queues; a negedge monitor consumes them.
module tb_fs_dither_core;
  localparam int W = 320;

  logic        clk_in = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst_in = 1'b0;
  logic        pix_valid_in = 1'b0;
  logic [10:0] pix_hcount_in = '0;
  logic [9:0]  pix_vcount_in = '0;
  logic [7:0]  cur_pixel_in = '0;
  logic [7:0]  next_pixel_in = '0;
  logic        diffuse_en_in = 1'b0;
  logic        dith_valid_out, dith_pixel_out, wr_valid_out, row_overrun_out;
  logic [10:0] dith_hcount_out;
  logic [9:0]  dith_vcount_out;
  logic [8:0]  wr_addr_out;
  logic [7:0]  wr_data_out;

  fs_dither_core #(.FRAME_WIDTH(W), .THRESHOLD(128)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pix_valid_in(pix_valid_in),
    .pix_hcount_in(pix_hcount_in), .pix_vcount_in(pix_vcount_in),
    .cur_pixel_in(cur_pixel_in), .next_pixel_in(next_pixel_in),
    .diffuse_en_in(diffuse_en_in), .dith_valid_out(dith_valid_out),
    .dith_pixel_out(dith_pixel_out), .dith_hcount_out(dith_hcount_out),
    .dith_vcount_out(dith_vcount_out), .wr_valid_out(wr_valid_out),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .row_overrun_out(row_overrun_out)
  );

  always #5 if (clk_run) clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct { int bitv; int h; int v; int stamp; } dith_t;
  typedef struct { int addr; int data; int stamp; } wr_t;
  dith_t dq[$];
  wr_t   wq[$];
  int    oq[$];
  int checks = 0;
  int errors = 0;

  int m_mode = 0;
  int m_prev = 0;
  int m_err = 0;
  int m_acc[W];

  function automatic int fdiv16(input int a);
    return (a >= 0) ? a / 16 : -((-a + 15) / 16);
  endfunction

  function automatic int clamp255(input int a);
    return (a < 0) ? 0 : (a > 255) ? 255 : a;
  endfunction

  task automatic m_pixel(input int x, input int v, input int cur, input int nxt,
                         input logic diff, input logic restart, input int stamp);
    int vv, b, e;
    dith_t d;
    wr_t w;
    if (restart) begin
      foreach (m_acc[i]) m_acc[i] = 0;
      m_err = 0;
    end
    if (diff) begin
      vv = clamp255(cur + m_err);
      b  = (vv >= 128) ? 1 : 0;
      e  = vv - (b == 1 ? 255 : 0);
    end else begin
      b = (cur >= 128) ? 1 : 0;
      e = 0;
    end
    d.bitv = b; d.h = x; d.v = v; d.stamp = stamp;
    dq.push_back(d);
    if (x > 0) begin
      w.addr = x - 1; w.data = clamp255(m_acc[x-1] + fdiv16(3 * e)); w.stamp = stamp;
      wq.push_back(w);
    end
    m_acc[x] = m_acc[x] + fdiv16(5 * e);
    if (x < W - 1) m_acc[x+1] = nxt + fdiv16(e);
    m_err  = diff ? fdiv16(7 * e) : 0;
    m_prev = x;
  endtask

  // Modes: 0 waiting for a row, 1 inside a row, 2 last pixel just seen (flush due).
  task automatic m_cycle(input logic vld, input int h, input int v, input int cur,
                         input int nxt, input logic diff);
    int stamp;
    wr_t w;
    stamp = cyc + 2;
    case (m_mode)
      2: begin
        if (vld) begin
          oq.push_back(stamp);
          m_pixel(h, v, cur, nxt, diff, 1'b1, stamp);
          m_mode = (h == W - 1) ? 2 : 1;
        end else begin
          w.addr = W - 1; w.data = clamp255(m_acc[W-1]); w.stamp = stamp;
          wq.push_back(w);
          m_mode = 0;
        end
      end
      1: begin
        if (vld) begin
          m_pixel(h, v, cur, nxt, diff, (h == 0) || (h != m_prev + 1), stamp);
          m_mode = (h == W - 1) ? 2 : 1;
        end
      end
      default: begin
        if (vld && h == 0) begin
          m_pixel(h, v, cur, nxt, diff, 1'b1, stamp);
          m_mode = (h == W - 1) ? 2 : 1;
        end
      end
    endcase
  endtask

  task automatic drive(input logic vld, input int h, input int v, input int cur,
                       input int nxt, input logic diff);
    @(negedge clk_in);
    pix_valid_in  = vld;
    pix_hcount_in = 11'(h);
    pix_vcount_in = 10'(v);
    cur_pixel_in  = 8'(cur);
    next_pixel_in = 8'(nxt);
    diffuse_en_in = diff;
    m_cycle(vld, h, v, cur, nxt, diff);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  // kind: 0 flat 128, 1 lone 200 over zeros, 2 bypass ramp, 3 random, 4 random with hcount jump
  task automatic send_row(input int v, input int kind, input int bub_pct);
    int x, cur, nxt;
    logic diff;
    x = 0;
    while (x < W) begin
      if (bub_pct > 0 && $urandom_range(0, 99) < bub_pct) idle($urandom_range(1, 3));
      case (kind)
        0: begin cur = 128; nxt = 128; diff = 1'b1; end
        1: begin cur = (x == 0) ? 200 : 0; nxt = 0; diff = 1'b1; end
        2: begin cur = x % 256; nxt = $urandom_range(0, 255); diff = 1'b0; end
        default: begin
          cur  = $urandom_range(0, 255);
          nxt  = $urandom_range(0, 255);
          diff = ($urandom_range(0, 9) != 0);
        end
      endcase
      drive(1'b1, x, v, cur, nxt, diff);
      x = (kind == 4 && x == 99) ? 150 : x + 1;
    end
  endtask

  task automatic check_val(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_dith_valid"}, int'(dith_valid_out), 0);
    check_val({tag, "_dith_pixel"}, int'(dith_pixel_out), 0);
    check_val({tag, "_dith_hcount"}, int'(dith_hcount_out), 0);
    check_val({tag, "_dith_vcount"}, int'(dith_vcount_out), 0);
    check_val({tag, "_wr_valid"}, int'(wr_valid_out), 0);
    check_val({tag, "_wr_addr"}, int'(wr_addr_out), 0);
    check_val({tag, "_wr_data"}, int'(wr_data_out), 0);
    check_val({tag, "_overrun"}, int'(row_overrun_out), 0);
  endtask

  always @(negedge clk_in) begin
    if (rst_in) begin
      while (dq.size() > 0 && dq[0].stamp < cyc) begin
        checks++; errors++;
        $display("FAIL dith_missing: actual=none required h=%0d v=%0d at cycle %0d", dq[0].h, dq[0].v, dq[0].stamp);
        dq.delete(0);
      end
      while (wq.size() > 0 && wq[0].stamp < cyc) begin
        checks++; errors++;
        $display("FAIL wr_missing: actual=none required addr=%0d data=%0d at cycle %0d", wq[0].addr, wq[0].data, wq[0].stamp);
        wq.delete(0);
      end
      while (oq.size() > 0 && oq[0] < cyc) begin
        checks++; errors++;
        $display("FAIL overrun_missing: actual=none required pulse at cycle %0d", oq[0]);
        oq.delete(0);
      end
      if (dith_valid_out) begin
        checks++;
        if (dq.size() == 0 || dq[0].stamp != cyc || dq[0].bitv != int'(dith_pixel_out) ||
            dq[0].h != int'(dith_hcount_out) || dq[0].v != int'(dith_vcount_out)) begin
          errors++;
          if (dq.size() == 0)
            $display("FAIL dith_unexpected: actual h=%0d bit=%0d cycle %0d required none", dith_hcount_out, dith_pixel_out, cyc);
          else
            $display("FAIL dith: actual h=%0d v=%0d bit=%0d cycle %0d required h=%0d v=%0d bit=%0d cycle %0d",
                     dith_hcount_out, dith_vcount_out, dith_pixel_out, cyc, dq[0].h, dq[0].v, dq[0].bitv, dq[0].stamp);
        end
        if (dq.size() > 0 && dq[0].stamp == cyc) dq.delete(0);
      end
      if (wr_valid_out) begin
        checks++;
        if (wq.size() == 0 || wq[0].stamp != cyc || wq[0].addr != int'(wr_addr_out) ||
            wq[0].data != int'(wr_data_out)) begin
          errors++;
          if (wq.size() == 0)
            $display("FAIL wr_unexpected: actual addr=%0d data=%0d cycle %0d required none", wr_addr_out, wr_data_out, cyc);
          else
            $display("FAIL wr: actual addr=%0d data=%0d cycle %0d required addr=%0d data=%0d cycle %0d",
                     wr_addr_out, wr_data_out, cyc, wq[0].addr, wq[0].data, wq[0].stamp);
        end
        if (wq.size() > 0 && wq[0].stamp == cyc) wq.delete(0);
      end
      if (row_overrun_out) begin
        checks++;
        if (oq.size() == 0 || oq[0] != cyc) begin
          errors++;
          $display("FAIL overrun: actual pulse at cycle %0d required %0d", cyc, (oq.size() > 0) ? oq[0] : -1);
        end
        if (oq.size() > 0 && oq[0] == cyc) oq.delete(0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk_in);
    check_all_zero("por");
    rst_in = 1'b1;
    idle(2);

    send_row(0, 0, 0);  idle(1);
    send_row(1, 1, 0);  idle(1);
    send_row(2, 2, 0);  idle(2);
    send_row(3, 3, 10); idle(1);
    send_row(4, 3, 15); idle(3);
    send_row(5, 3, 0);
    send_row(6, 3, 0);  idle(1);
    send_row(7, 4, 5);  idle(1);

    for (int x = 0; x < 60; x++)
      drive(1'b1, x, 8, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
    clk_run = 1'b0;
    pix_valid_in = 1'b0;
    rst_in = 1'b0;
    #1;
    check_all_zero("midrow_rst");
    dq.delete();
    wq.delete();
    oq.delete();
    m_mode = 0;
    #20 rst_in = 1'b1;
    #20 clk_run = 1'b1;

    idle(2);
    send_row(9, 0, 0);   idle(1);
    send_row(10, 3, 20); idle(1);
    idle(6);

    check_val("dith_queue_drained", dq.size(), 0);
    check_val("wr_queue_drained", wq.size(), 0);
    check_val("overrun_queue_drained", oq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
